// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - state codes, opcodes, ALU and operand-select encodings for control_unit
package cu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_RESET    = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_EXEC_R   = 4'd3;
    localparam state_t S_WB_R     = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WB   = 4'd7;
    localparam state_t S_MEM_WR   = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JUMP     = 4'd10;
    localparam state_t S_HALT     = 4'd11;

    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_OR   = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [2:0] SRCB_TWO     = 3'b000;
    localparam logic [2:0] SRCB_B       = 3'b001;
    localparam logic [2:0] SRCB_SEXT4   = 3'b010;
    localparam logic [2:0] SRCB_SEXT4_2 = 3'b011;
    localparam logic [2:0] SRCB_SEXT12  = 3'b100;

    function automatic logic [1:0] r_alu_op(input logic [3:0] opc);
        case (opc)
            OP_SUB:  r_alu_op = ALU_SUB;
            OP_AND:  r_alu_op = ALU_AND;
            OP_OR:   r_alu_op = ALU_OR;
            default: r_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control strobes and status between control_unit and the datapath
interface control_unit_if;
    logic [15:0] ir;
    logic        alu_zero;
    logic        rst_ir;
    logic        rst_pc;
    logic        rst_alu_out;
    logic        rst_mdr;
    logic [2:0]  rst_ABC;
    logic        pc_wr;
    logic        pc_src;
    logic        memr;
    logic        memw;
    logic        output_cont;
    logic [1:0]  regA;
    logic        regB;
    logic        read3;
    logic        alu_srcA;
    logic [2:0]  alu_srcB;
    logic [1:0]  alu_op;
    logic        eqb;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_wr;
    logic        illegal;
    logic        halted;

    modport master (
        input  ir, alu_zero,
        output rst_ir, rst_pc, rst_alu_out, rst_mdr, rst_ABC, pc_wr, pc_src,
               memr, memw, output_cont, regA, regB, read3, alu_srcA, alu_srcB,
               alu_op, eqb, reg_dst, mem_to_reg, reg_wr, illegal, halted
    );

    modport slave (
        output ir, alu_zero,
        input  rst_ir, rst_pc, rst_alu_out, rst_mdr, rst_ABC, pc_wr, pc_src,
               memr, memw, output_cont, regA, regB, read3, alu_srcA, alu_srcB,
               alu_op, eqb, reg_dst, mem_to_reg, reg_wr, illegal, halted
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle control FSM for the 16-bit datapath
// Define CU_HALT_EN to make opcode F enter HALT; otherwise it is treated as illegal.
module control_unit
    import cu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    control_unit_if.master  bus
);

    state_t            state, next_state;
    logic [OPC_W-1:0]  opc;
    logic [3:0]        opc4;
    logic              unused_ir;

    assign opc       = bus.ir[15 -: OPC_W];
    assign opc4      = 4'(opc);
    assign unused_ir = ^bus.ir[15-OPC_W:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= next_state;
    end

    always_comb begin
        next_state      = state;
        bus.rst_ir      = 1'b0;
        bus.rst_pc      = 1'b0;
        bus.rst_alu_out = 1'b0;
        bus.rst_mdr     = 1'b0;
        bus.rst_ABC     = 3'b000;
        bus.pc_wr       = 1'b0;
        bus.pc_src      = 1'b0;
        bus.memr        = 1'b0;
        bus.memw        = 1'b0;
        bus.output_cont = 1'b0;
        bus.regA        = 2'b00;
        bus.regB        = 1'b0;
        bus.read3       = 1'b0;
        bus.alu_srcA    = 1'b0;
        bus.alu_srcB    = SRCB_TWO;
        bus.alu_op      = ALU_ADD;
        bus.eqb         = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_wr      = 1'b0;
        bus.illegal     = 1'b0;

        case (state)
            S_RESET: begin
                bus.rst_ir      = 1'b1;
                bus.rst_pc      = 1'b1;
                bus.rst_alu_out = 1'b1;
                bus.rst_mdr     = 1'b1;
                bus.rst_ABC     = 3'b111;
                next_state      = S_FETCH;
            end
            S_FETCH: begin
                bus.memr   = 1'b1;
                bus.pc_wr  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC+2+offset is precomputed into ALUOut here.
                bus.read3    = 1'b1;
                bus.alu_srcB = SRCB_SEXT4_2;
                case (opc4)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: next_state = S_EXEC_R;
                    OP_LW, OP_SW:                  next_state = S_MEM_ADDR;
                    OP_BEQ:                        next_state = S_BRANCH;
                    OP_JMP:                        next_state = S_JUMP;
`ifdef CU_HALT_EN
                    OP_HALT:                       next_state = S_HALT;
`endif
                    default: begin
                        bus.illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_srcA = 1'b1;
                bus.alu_srcB = SRCB_B;
                bus.alu_op   = r_alu_op(opc4);
                next_state   = S_WB_R;
            end
            S_WB_R: begin
                bus.reg_wr = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_srcA = 1'b1;
                bus.alu_srcB = SRCB_SEXT4;
                next_state   = (opc4 == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.memr        = 1'b1;
                bus.output_cont = 1'b1;
                next_state      = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_wr     = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_WR: begin
                bus.memw        = 1'b1;
                bus.output_cont = 1'b1;
                bus.regB        = 1'b1;
                next_state      = S_FETCH;
            end
            S_BRANCH: begin
                bus.eqb      = 1'b1;
                bus.alu_srcA = 1'b1;
                bus.alu_srcB = SRCB_B;
                bus.alu_op   = ALU_SUB;
                bus.pc_src   = 1'b1;
                bus.pc_wr    = bus.alu_zero;
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                bus.alu_srcB = SRCB_SEXT12;
                bus.pc_wr    = 1'b1;
                next_state   = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

`ifdef CU_HALT_EN
    assign bus.halted = (state == S_HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_unit_if bus();

    control_unit #(.OPC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.ir       = 16'h0000;
        bus.alu_zero = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ABC", 32'(bus.rst_ABC), 32'h7);
        chk("rst_ir", 32'(bus.rst_ir), 32'h1);
        chk("rst_pc", 32'(bus.rst_pc), 32'h1);
        chk("rst_alu_out", 32'(bus.rst_alu_out), 32'h1);
        chk("rst_mdr", 32'(bus.rst_mdr), 32'h1);
        chk("rst_memr", 32'(bus.memr), 32'h0);
        chk("rst_pc_wr", 32'(bus.pc_wr), 32'h0);

        bus.ir = 16'h8312;
        rst = 1'b0;
        step();
        chk("fetch_memr", 32'(bus.memr), 32'h1);
        chk("fetch_pc_wr", 32'(bus.pc_wr), 32'h1);
        chk("fetch_rst_pc", 32'(bus.rst_pc), 32'h0);
        step();
        chk("add_dec_read3", 32'(bus.read3), 32'h1);
        chk("add_dec_srcB", 32'(bus.alu_srcB), 32'h3);
        chk("add_dec_illegal", 32'(bus.illegal), 32'h0);
        step();
        chk("add_exec_op", 32'(bus.alu_op), 32'h0);
        chk("add_exec_srcB", 32'(bus.alu_srcB), 32'h1);
        chk("add_exec_srcA", 32'(bus.alu_srcA), 32'h1);
        step();
        chk("add_wb_reg_wr", 32'(bus.reg_wr), 32'h1);
        chk("add_wb_m2r", 32'(bus.mem_to_reg), 32'h0);
        step();
        chk("add_next_fetch", 32'(bus.memr), 32'h1);

        bus.ir = 16'hC134;
        step();
        step();
        chk("sub_exec_op", 32'(bus.alu_op), 32'h1);
        step();
        chk("sub_wb_reg_wr", 32'(bus.reg_wr), 32'h1);
        step();
        chk("sub_next_fetch", 32'(bus.pc_wr), 32'h1);

        bus.ir = 16'h1123;
        step();
        chk("lw_dec_memr", 32'(bus.memr), 32'h0);
        step();
        chk("lw_addr_srcB", 32'(bus.alu_srcB), 32'h2);
        chk("lw_addr_srcA", 32'(bus.alu_srcA), 32'h1);
        step();
        chk("lw_rd_memr", 32'(bus.memr), 32'h1);
        chk("lw_rd_oc", 32'(bus.output_cont), 32'h1);
        step();
        chk("lw_wb_m2r", 32'(bus.mem_to_reg), 32'h1);
        chk("lw_wb_reg_wr", 32'(bus.reg_wr), 32'h1);
        step();
        chk("lw_next_fetch", 32'(bus.memr), 32'h1);
        chk("lw_next_oc", 32'(bus.output_cont), 32'h0);

        bus.ir = 16'h3012;
        bus.alu_zero = 1'b1;
        step();
        step();
        chk("beq1_eqb", 32'(bus.eqb), 32'h1);
        chk("beq1_pc_wr", 32'(bus.pc_wr), 32'h1);
        chk("beq1_pc_src", 32'(bus.pc_src), 32'h1);
        chk("beq1_alu_op", 32'(bus.alu_op), 32'h1);
        step();
        chk("beq1_next_fetch", 32'(bus.memr), 32'h1);
        bus.alu_zero = 1'b0;
        step();
        step();
        chk("beq0_eqb", 32'(bus.eqb), 32'h1);
        chk("beq0_pc_wr", 32'(bus.pc_wr), 32'h0);
        step();
        chk("beq0_next_fetch", 32'(bus.memr), 32'h1);

        bus.ir = 16'h5000;
        step();
        chk("ill_pulse", 32'(bus.illegal), 32'h1);
        chk("ill_reg_wr", 32'(bus.reg_wr), 32'h0);
        chk("ill_memw", 32'(bus.memw), 32'h0);
        step();
        chk("ill_cleared", 32'(bus.illegal), 32'h0);
        chk("ill_next_fetch", 32'(bus.memr), 32'h1);

        bus.ir = 16'h4000;
        step();
        step();
        chk("jmp_srcB", 32'(bus.alu_srcB), 32'h4);
        chk("jmp_pc_wr", 32'(bus.pc_wr), 32'h1);
        chk("jmp_pc_src", 32'(bus.pc_src), 32'h0);
        step();
        chk("jmp_next_fetch", 32'(bus.memr), 32'h1);

        bus.ir = 16'h2123;
        step();
        step();
        chk("sw_addr_srcB", 32'(bus.alu_srcB), 32'h2);
        step();
        chk("sw_memw", 32'(bus.memw), 32'h1);
        chk("sw_memr", 32'(bus.memr), 32'h0);
        chk("sw_regB", 32'(bus.regB), 32'h1);
        rst = 1'b1;
        #1;
        chk("sw_rst_memw", 32'(bus.memw), 32'h0);
        chk("sw_rst_pc", 32'(bus.rst_pc), 32'h1);
        @(negedge clk);
        chk("sw_rst_hold_reg_wr", 32'(bus.reg_wr), 32'h0);
        bus.ir = 16'h0000;
        rst = 1'b0;
        step();
        chk("sw_rst_fetch", 32'(bus.memr), 32'h1);

        bus.ir = 16'hF000;
        step();
`ifdef CU_HALT_EN
        chk("halt_dec_illegal", 32'(bus.illegal), 32'h0);
        step();
        chk("halt_halted", 32'(bus.halted), 32'h1);
        step();
        step();
        chk("halt_stays", 32'(bus.halted), 32'h1);
        chk("halt_memr", 32'(bus.memr), 32'h0);
        chk("halt_pc_wr", 32'(bus.pc_wr), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("halt_exit_halted", 32'(bus.halted), 32'h0);
        chk("halt_exit_fetch", 32'(bus.memr), 32'h1);
`else
        chk("f_illegal", 32'(bus.illegal), 32'h1);
        chk("f_halted", 32'(bus.halted), 32'h0);
        step();
        chk("f_next_fetch", 32'(bus.memr), 32'h1);
        chk("f_halted_fetch", 32'(bus.halted), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
